// File: rtl/tjmono_pkg.sv
// Shared definitions for the TJ-Monopix hit serializer: word layout,
// field positions, transmitter state encoding and the field Gray coder.
package tjmono_pkg;

    localparam int WORD_W = 27;
    localparam int CNT_W  = 5;

    localparam int COL_MSB = 26;
    localparam int COL_LSB = 21;
    localparam int ROW_MSB = 20;
    localparam int ROW_LSB = 12;
    localparam int LE_MSB  = 11;
    localparam int LE_LSB  = 6;
    localparam int TE_MSB  = 5;
    localparam int TE_LSB  = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    // Binary to reflected Gray code for one 6-bit timestamp field.
    function automatic logic [5:0] gray6(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray-code the LE and TE timestamps independently; column and row pass through.
    function automatic logic [WORD_W-1:0] gray_fields(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] g;
        g = w;
        g[LE_MSB:LE_LSB] = gray6(w[LE_MSB:LE_LSB]);
        g[TE_MSB:TE_LSB] = gray6(w[TE_MSB:TE_LSB]);
        return g;
    endfunction

endpackage

// File: rtl/tjmono_data_tx_if.sv
// Hit-input and readout-side signal bundle of the hit serializer.
// master: hit source plus serial receiver; slave: the serializer itself.
interface tjmono_data_tx_if;
    import tjmono_pkg::*;

    logic              HIT_WRITE;
    logic [WORD_W-1:0] HIT_DATA;
    logic              FREEZE;
    logic              READ;
    logic              TOKEN;
    logic              OUT;
    logic              HIT_FULL;
    logic [7:0]        LOST_CNT;

    modport master (
        output HIT_WRITE, HIT_DATA, FREEZE, READ,
        input  TOKEN, OUT, HIT_FULL, LOST_CNT
    );

    modport slave (
        input  HIT_WRITE, HIT_DATA, FREEZE, READ,
        output TOKEN, OUT, HIT_FULL, LOST_CNT
    );
endinterface

// File: rtl/tjmono_tx_fifo.sv
// Synchronous first-word-fall-through hit FIFO. The head word is always
// visible on rd_data while not empty. Pointers wrap at DEPTH (power of 2).
// full is a registered flag; empty_nxt exposes the post-edge emptiness so
// the owner can register flags that depend on it without a cycle of lag.
module tjmono_tx_fifo
    import tjmono_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              pop,
    output logic [WORD_W-1:0] rd_data,
    output logic              empty,
    output logic              empty_nxt,
    output logic              full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;

    // Occupancy after the coming edge.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    assign empty     = (count == '0);
    assign empty_nxt = (count_nxt == '0);
    assign rd_data   = mem[rd_ptr];

    // Pointer, occupancy and full-flag bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    // Storage array; contents are meaningless while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/tjmono_data_tx.sv
// TJ-Monopix hit serializer: buffers 27-bit hit words and sends them MSB
// first on OUT, one frame per READ request, 28 clocks per frame.
// Build option: define TJMONO_TX_GRAY_EN to Gray-code the LE and TE
// timestamp fields as the word leaves the FIFO (same latency either way).
module tjmono_data_tx
    import tjmono_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              CLK40,
    input  logic              RST_N,
    tjmono_data_tx_if.slave   bus
);

    logic              push;
    logic              pop;
    logic              drop;
    logic [WORD_W-1:0] head_word;
    logic [WORD_W-1:0] load_word;
    logic              fifo_empty;
    logic              fifo_empty_nxt;
    logic              fifo_full;

    tx_state_t         state;
    logic              shift_nxt;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              token;
    logic [7:0]        lost_cnt;

    // Full is the registered pre-edge flag, so a pop at the same edge
    // does not make room for a write that arrives while full.
    assign push = bus.HIT_WRITE & ~bus.FREEZE & ~fifo_full;
    assign drop = bus.HIT_WRITE & (bus.FREEZE | fifo_full);
    assign pop  = (state == IDLE) & bus.READ & ~fifo_empty;

    tjmono_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK40),
        .rst_n     (RST_N),
        .push      (push),
        .wr_data   (bus.HIT_DATA),
        .pop       (pop),
        .rd_data   (head_word),
        .empty     (fifo_empty),
        .empty_nxt (fifo_empty_nxt),
        .full      (fifo_full)
    );

`ifdef TJMONO_TX_GRAY_EN
    assign load_word = gray_fields(head_word);
`else
    assign load_word = head_word;
`endif

    // Whether the serializer will be in SHIFT after the coming edge.
    always_comb begin
        shift_nxt = 1'b0;
        if (state == IDLE) shift_nxt = pop;
        else               shift_nxt = (bit_cnt != '0);
    end

    // Frame FSM: load on pop, shift out 27 bits, one trailing zero bit in IDLE.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            token   <= 1'b0;
        end else begin
            token <= ~fifo_empty_nxt | shift_nxt;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= load_word;
                        bit_cnt <= CNT_W'(WORD_W - 1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Shifting in zeros leaves shreg clear once the frame ends,
                    // which is what holds OUT low in IDLE.
                    shreg <= {shreg[WORD_W-2:0], 1'b0};
                    if (bit_cnt == '0) state   <= IDLE;
                    else               bit_cnt <= bit_cnt - CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating count of hits refused because of freeze or a full FIFO.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            lost_cnt <= '0;
        end else if (drop && (lost_cnt != 8'hFF)) begin
            lost_cnt <= lost_cnt + 8'd1;
        end
    end

    assign bus.OUT      = shreg[WORD_W-1];
    assign bus.TOKEN    = token;
    assign bus.HIT_FULL = fifo_full;
    assign bus.LOST_CNT = lost_cnt;

endmodule

// File: tb/tb_tjmono_data_tx.sv
// Directed self-checking bench for tjmono_data_tx (DEPTH = 16).
module tb_tjmono_data_tx;

    logic CLK40;
    logic RST_N;
    int   n_chk;
    int   n_err;

    tjmono_data_tx_if bus ();

    tjmono_data_tx #(.DEPTH(16)) dut (
        .CLK40 (CLK40),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK40 = 1'b0;
    always #5 CLK40 = ~CLK40;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 2 ns after the edge.
    task automatic tick();
        @(posedge CLK40);
        #2;
    endtask

    function automatic logic [26:0] mk_word(input int i);
        return {6'(i + 1), 9'(3 * i + 7), 6'(i), 6'(63 - i)};
    endfunction

    // Expected frame content for a stored word in the current build.
    function automatic logic [26:0] exp_tx(input logic [26:0] w);
        logic [26:0] r;
        r = w;
`ifdef TJMONO_TX_GRAY_EN
        r[11:6] = w[11:6] ^ {1'b0, w[11:7]};
        r[5:0]  = w[5:0]  ^ {1'b0, w[5:1]};
`endif
        return r;
    endfunction

    task automatic write_word(input logic [26:0] w);
        bus.HIT_WRITE = 1'b1;
        bus.HIT_DATA  = w;
        tick();
        bus.HIT_WRITE = 1'b0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    // Request one frame, collect 27 bits, then check the trailing idle bit.
    // frz_at >= 0 issues three frozen writes starting at that bit.
    task automatic read_frame(input string tag, input logic [26:0] exp, input int frz_at,
                              output logic [26:0] got);
        bus.READ = 1'b1;
        tick();
        bus.READ = 1'b0;
        got[26] = bus.OUT;
        for (int k = 1; k < 27; k++) begin
            if (frz_at >= 0 && k >= frz_at && k < frz_at + 3) begin
                bus.HIT_WRITE = 1'b1;
                bus.FREEZE    = 1'b1;
                bus.HIT_DATA  = 27'h3FF_FFFF;
            end else begin
                bus.HIT_WRITE = 1'b0;
                bus.FREEZE    = 1'b0;
            end
            tick();
            got[26-k] = bus.OUT;
        end
        bus.HIT_WRITE = 1'b0;
        bus.FREEZE    = 1'b0;
        chk({tag, "_frame"}, 32'(got), 32'(exp));
        tick();
        chk({tag, "_tail_out"}, 32'(bus.OUT), 32'd0);
    endtask

    initial begin
        logic [26:0] got;
        logic [83:0] stream;
        logic [26:0] words3 [3];
        logic        tok82;
        logic        resid;

        n_chk = 0;
        n_err = 0;
        RST_N = 1'b0;
        bus.HIT_WRITE = 1'b0;
        bus.HIT_DATA  = '0;
        bus.FREEZE    = 1'b0;
        bus.READ      = 1'b0;
        #3;
        chk("rst_out",   32'(bus.OUT),      32'd0);
        chk("rst_token", 32'(bus.TOKEN),    32'd0);
        chk("rst_full",  32'(bus.HIT_FULL), 32'd0);
        chk("rst_lost",  32'(bus.LOST_CNT), 32'd0);
        tick();
        RST_N = 1'b1;
        tick();

        // READ with nothing stored is ignored.
        bus.READ = 1'b1;
        tick();
        tick();
        bus.READ = 1'b0;
        chk("empty_read_out",   32'(bus.OUT),   32'd0);
        chk("empty_read_token", 32'(bus.TOKEN), 32'd0);

        // Single word 27'h5A5A5A5.
        write_word(27'h5A5A5A5);
        chk("single_token_pre", 32'(bus.TOKEN), 32'd1);
        read_frame("single", exp_tx(27'h5A5A5A5), -1, got);
        chk("single_token_post", 32'(bus.TOKEN), 32'd0);

        // Overflow: 20 writes into 16 entries.
        for (int i = 0; i < 20; i++) begin
            write_word(mk_word(i));
            if (i == 14) chk("ovf_full_at15", 32'(bus.HIT_FULL), 32'd0);
            if (i == 15) chk("ovf_full_at16", 32'(bus.HIT_FULL), 32'd1);
        end
        chk("ovf_lost", 32'(bus.LOST_CNT), 32'd4);
        chk("ovf_full", 32'(bus.HIT_FULL), 32'd1);
        // A write at the same edge as the first pop is still refused.
        bus.HIT_WRITE = 1'b1;
        bus.HIT_DATA  = 27'h1234567;
        bus.READ      = 1'b1;
        tick();
        bus.HIT_WRITE = 1'b0;
        bus.READ      = 1'b0;
        chk("ovf_pop_write_lost", 32'(bus.LOST_CNT), 32'd5);
        chk("ovf_full_after_pop", 32'(bus.HIT_FULL), 32'd0);
        got[26] = bus.OUT;
        for (int k = 1; k < 27; k++) begin
            tick();
            got[26-k] = bus.OUT;
        end
        chk("ovf_word0", 32'(got), 32'(exp_tx(mk_word(0))));
        tick();
        for (int i = 1; i < 16; i++) begin
            read_frame($sformatf("ovf_word%0d", i), exp_tx(mk_word(i)), -1, got);
        end
        chk("ovf_token_drained", 32'(bus.TOKEN), 32'd0);

        // Freeze during a transfer.
        do_reset();
        write_word(27'h2C3_5A17);
        read_frame("freeze", exp_tx(27'h2C3_5A17), 5, got);
        chk("freeze_lost",  32'(bus.LOST_CNT), 32'd3);
        chk("freeze_token", 32'(bus.TOKEN),    32'd0);
        bus.FREEZE = 1'b1;
        write_word(27'h0000001);
        bus.FREEZE = 1'b0;
        chk("freeze_idle_lost",  32'(bus.LOST_CNT), 32'd4);
        chk("freeze_idle_token", 32'(bus.TOKEN),    32'd0);

        // READ held high with three stored words.
        words3[0] = 27'h6ABCDEF;
        words3[1] = 27'h5555555;
        words3[2] = 27'h7123456;
        for (int i = 0; i < 3; i++) write_word(words3[i]);
        bus.READ = 1'b1;
        tok82 = 1'b0;
        for (int c = 0; c < 84; c++) begin
            tick();
            stream[c] = bus.OUT;
            if (c == 82) tok82 = bus.TOKEN;
        end
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 27; k++) got[26-k] = stream[28*f + k];
            chk($sformatf("held_frame%0d", f), 32'(got), 32'(exp_tx(words3[f])));
            chk($sformatf("held_gap%0d", f), 32'(stream[28*f + 27]), 32'd0);
        end
        chk("held_token_last_bit", 32'(tok82),     32'd1);
        chk("held_token_end",      32'(bus.TOKEN), 32'd0);
        tick();
        bus.READ = 1'b0;
        chk("held_idle_out", 32'(bus.OUT), 32'd0);

        // Reset in the middle of a frame of all ones.
        write_word(27'h7FFFFFF);
        bus.READ = 1'b1;
        tick();
        bus.READ = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        chk("midrst_out_before", 32'(bus.OUT), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("midrst_out",   32'(bus.OUT),      32'd0);
        chk("midrst_token", 32'(bus.TOKEN),    32'd0);
        chk("midrst_lost",  32'(bus.LOST_CNT), 32'd0);
        tick();
        tick();
        RST_N = 1'b1;
        resid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            resid = resid | bus.OUT | bus.TOKEN;
        end
        chk("midrst_residual", 32'(resid), 32'd0);

        // LE = 5, TE = 63 timestamp vector.
        write_word({6'd1, 9'd2, 6'd5, 6'd63});
        read_frame("ts", exp_tx({6'd1, 9'd2, 6'd5, 6'd63}), -1, got);
`ifdef TJMONO_TX_GRAY_EN
        chk("ts_le", 32'(got[11:6]), 32'(6'b000111));
        chk("ts_te", 32'(got[5:0]),  32'(6'b100000));
`else
        chk("ts_le", 32'(got[11:6]), 32'd5);
        chk("ts_te", 32'(got[5:0]),  32'd63);
`endif
        chk("ts_colrow", 32'(got[26:12]), 32'({6'd1, 9'd2}));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tjmono_data_tx.md
TJMONO_DATA_TX -- requirements
Module: tjmono_data_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 16, hit FIFO depth in words (power of 2, 4..64).
REQ-002 SHALL have port CLK40 input 1: sole clock; all logic on rising edge.
REQ-003 SHALL have port RST_N input 1: reset, asynchronous and active-low.
REQ-004 SHALL have port HIT_WRITE input 1: write strobe for one hit word.
REQ-005 SHALL have port HIT_DATA input 27: hit word, {COL[26:21], ROW[20:12], LE[11:6], TE[5:0]}.
REQ-006 SHALL have port FREEZE input 1: readout freeze from receiver.
REQ-007 SHALL have port READ input 1: word read request from receiver.
REQ-008 SHALL have port TOKEN output 1: data pending.
REQ-009 SHALL have port OUT output 1: serial data, MSB first.
REQ-010 SHALL have port HIT_FULL output 1: FIFO full.
REQ-011 SHALL have port LOST_CNT output 8: dropped-hit counter.

Function
REQ-012 SHALL store HIT_DATA into the FIFO at an edge where HIT_WRITE=1, FREEZE=0 and HIT_FULL=0 (full evaluated before the edge, even if a pop occurs at the same edge).
REQ-013 SHALL drop the hit and increment LOST_CNT when HIT_WRITE=1 and (HIT_FULL=1 or FREEZE=1); LOST_CNT saturates at 8'hFF.
REQ-014 SHALL implement FSM states IDLE and SHIFT with a 5-bit bit counter.
REQ-015 SHALL, in IDLE at edge n with READ=1 and FIFO non-empty, pop one word, load a 27-bit shift register, set counter to 26 and enter SHIFT.
REQ-016 SHALL drive OUT from shift-register bit 26, registered: OUT = word bit 26 after edge n, bit 0 after edge n+26.
REQ-017 SHALL shift left one bit per edge in SHIFT, decrement the counter, and return to IDLE at edge n+27 with OUT=0.
REQ-018 SHALL ignore READ while in SHIFT; the next word is accepted no earlier than edge n+28.
REQ-019 SHALL ignore READ in IDLE when the FIFO is empty; OUT stays 0.
REQ-020 SHALL register TOKEN = (FIFO non-empty) or (state SHIFT); TOKEN falls at the edge that returns to IDLE with an empty FIFO.
REQ-021 SHALL NOT let FREEZE affect a transfer already in SHIFT or words already stored.
REQ-022 SHALL register HIT_FULL = (occupancy == DEPTH).

Reset
REQ-023 SHALL, on RST_N=0, immediately set state IDLE, FIFO empty, shift register 0, counter 0, OUT=0, TOKEN=0, HIT_FULL=0 and LOST_CNT=0.
REQ-024 SHALL abort a transfer when reset occurs mid-SHIFT; the word is lost and not counted.
REQ-025 SHALL release reset synchronously to CLK40 from the next rising edge after RST_N=1.

Configuration
REQ-026 SHALL Gray-encode the LE and TE fields independently at pop time when TJMONO_TX_GRAY_EN is defined (g = b ^ (b>>1)), all other bits unchanged.
REQ-027 SHALL transmit LE/TE in binary when TJMONO_TX_GRAY_EN is undefined; latency is identical in both builds.

Structure
REQ-028 SHALL place WORD_W=27, field MSB/LSB constants, and the state enum in shared package tjmono_pkg.
REQ-029 SHALL implement storage in sub-module tjmono_tx_fifo (synchronous, first-word-fall-through, DEPTH parameter, pointer wrap at DEPTH).

Verification
REQ-030 SHALL cover a single word: write 27'h5A5A5A5, then READ pulse -> TOKEN=1 before READ, OUT bits 1011010010110100101101001... MSB first over 27 cycles, TOKEN=0 after edge n+27.
REQ-031 SHALL cover overflow: 20 writes with DEPTH=16 and no READ -> HIT_FULL=1 after the 16th write, LOST_CNT=4, and the 16 stored words are read back in order.
REQ-032 SHALL cover freeze: FREEZE=1 with 3 writes -> LOST_CNT=3, TOKEN unchanged; a transfer in progress completes bit-exact.
REQ-033 SHALL cover READ held high continuously with 3 words stored -> back-to-back frames 28 cycles apart, TOKEN=0 after the third frame.
REQ-034 SHALL cover reset mid-shift: RST_N=0 at bit 10 -> OUT=0, TOKEN=0 and LOST_CNT=0 immediately; no residual bits after release.
REQ-035 SHALL cover the Gray build with LE=6'd5, TE=6'd63 -> transmitted LE=6'b000111, TE=6'b100000.
